tag_mem: RTL and testbench



---
 rtl/tag_mem_pkg.sv | 18 +
 rtl/tag_mem_lru_tracker.sv | 49 ++++
 rtl/tag_mem.sv | 85 ++++++++
 tb/tb_tag_mem.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/tag_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tag_mem_pkg
// Purpose  : Shared widths and the tag-slice helper for the tag store.
// Revision : 1.0 - initial release
// ============================================================================
package tag_mem_pkg;
    localparam int ADDR_W   = 14;
    localparam int TAG_W    = 9;
    localparam int OFFSET_W = 5;
    localparam int WAYS     = 8;
    localparam int WAY_W    = 3;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:OFFSET_W];
    endfunction
endpackage
`default_nettype wire

// File: rtl/tag_mem_lru_tracker.sv
`default_nettype none
// ============================================================================
// Module   : lru_tracker
// Purpose  : True-LRU age matrix for 8 ways; ages stay a permutation of 0..7.
// Revision : 1.0 - initial release
// ============================================================================
module lru_tracker
    import tag_mem_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_touch_en,
    input  logic [WAY_W-1:0] i_touch_way,
    output logic [WAY_W-1:0] o_lru_way
);

    logic [WAY_W-1:0] r_age [WAYS];
    logic [WAY_W-1:0] w_touch_age;

    assign w_touch_age = r_age[i_touch_way];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WAYS; i++) begin
                r_age[i] <= WAY_W'(i);
            end
        end else if (i_touch_en) begin
            // Younger-than-touched ways age by one; touched way becomes MRU.
            for (int i = 0; i < WAYS; i++) begin
                if (WAY_W'(i) == i_touch_way) begin
                    r_age[i] <= '0;
                end else if (r_age[i] < w_touch_age) begin
                    r_age[i] <= r_age[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_lru_way = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (r_age[i] == WAY_W'(WAYS - 1)) begin
                o_lru_way = WAY_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tag_mem.sv
`default_nettype none
// ============================================================================
// Module   : tag_mem
// Purpose  : 8-way fully-associative tag store with true-LRU replacement.
// Revision : 1.0 - initial release
// ============================================================================
module tag_mem
    import tag_mem_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr,
    input  logic              md,
    output logic [TAG_W-1:0]  tegOut,
    output logic [WAY_W-1:0]  chan,
    output logic              hit
);

    logic [WAYS-1:0]  r_valid;
    logic [TAG_W-1:0] r_tag [WAYS];

    logic [TAG_W-1:0] w_tag;
    logic [WAYS-1:0]  w_match;
    logic [WAY_W-1:0] w_hit_way;
    logic [WAY_W-1:0] w_free_way;
    logic             w_has_free;
    logic [WAY_W-1:0] w_lru_way;
    logic             w_touch_en;

    assign w_tag = addr_tag(addr);

    generate
        for (genvar g = 0; g < WAYS; g++) begin : g_match
            assign w_match[g] = r_valid[g] && (r_tag[g] == w_tag);
        end
    endgenerate

    assign hit = |w_match;

    always_comb begin
        w_hit_way  = '0;
        w_free_way = '0;
        w_has_free = 1'b0;
        for (int i = 0; i < WAYS; i++) begin
            if (w_match[i]) begin
                w_hit_way = WAY_W'(i);
            end
        end
        // Descending scan leaves the lowest invalid index as the winner.
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_free_way = WAY_W'(i);
                w_has_free = 1'b1;
            end
        end
    end

    assign chan   = hit ? w_hit_way : (w_has_free ? w_free_way : w_lru_way);
    assign tegOut = r_tag[chan];

    assign w_touch_en = wr || (md && hit);

    always_ff @(posedge clk) begin
        if (reset_n) begin
            r_valid <= '0;
            for (int i = 0; i < WAYS; i++) begin
                r_tag[i] <= '0;
            end
        end else if (wr && !hit) begin
            r_tag[chan]   <= w_tag;
            r_valid[chan] <= 1'b1;
        end
    end

    lru_tracker u_lru (
        .clk         (clk),
        .rst         (reset_n),
        .i_touch_en  (w_touch_en),
        .i_touch_way (chan),
        .o_lru_way   (w_lru_way)
    );

endmodule
`default_nettype wire

// File: tb/tb_tag_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_tag_mem
// Purpose  : Directed, table-driven self-checking bench for tag_mem.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tag_mem;

    typedef struct {
        logic [13:0] addr;
        logic        wr;
        logic        md;
        logic        exp_hit;
        logic [2:0]  exp_chan;
        logic [8:0]  exp_teg;
    } vec_t;

    logic        clk;
    logic        reset_n;
    logic [13:0] addr;
    logic        wr;
    logic        md;
    logic [8:0]  tegOut;
    logic [2:0]  chan;
    logic        hit;

    int checks;
    int errors;
    vec_t vecs[$];

    tag_mem dut (
        .clk     (clk),
        .reset_n (reset_n),
        .addr    (addr),
        .wr      (wr),
        .md      (md),
        .tegOut  (tegOut),
        .chan    (chan),
        .hit     (hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [13:0] a, input logic w, input logic m,
                                input logic h, input logic [2:0] c, input logic [8:0] t);
        vec_t v;
        v.addr = a; v.wr = w; v.md = m;
        v.exp_hit = h; v.exp_chan = c; v.exp_teg = t;
        return v;
    endfunction

    task automatic check(input string name, input logic h, input logic [2:0] c,
                         input logic [8:0] t);
        checks += 3;
        if (hit !== h) begin
            errors++;
            $display("FAIL %s hit: got %0b want %0b", name, hit, h);
        end
        if (chan !== c) begin
            errors++;
            $display("FAIL %s chan: got %0d want %0d", name, chan, c);
        end
        if (tegOut !== t) begin
            errors++;
            $display("FAIL %s tegOut: got 0x%03h want 0x%03h", name, tegOut, t);
        end
    endtask

    // Present addr, check the combinational outputs, then pulse wr/md for one edge.
    task automatic apply(input string name, input vec_t v);
        @(negedge clk);
        addr = v.addr; wr = 1'b0; md = 1'b0;
        #1;
        check(name, v.exp_hit, v.exp_chan, v.exp_teg);
        wr = v.wr; md = v.md;
        @(posedge clk);
        #1;
        wr = 1'b0; md = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0;
        reset_n = 1'b1; addr = '0; wr = 1'b0; md = 1'b0;

        // Main sequence from reset: first allocation, fill, eviction, md touch.
        vecs.push_back(mk(14'h000, 1, 0, 0, 3'd0, 9'h000));
        vecs.push_back(mk(14'h000, 0, 0, 1, 3'd0, 9'h000));
        for (int k = 1; k < 8; k++)
            vecs.push_back(mk(14'(k * 14'h40), 1, 0, 0, 3'(k), 9'h000));
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk(14'(k * 14'h40), 0, 0, 1, 3'(k), 9'(2 * k)));
        vecs.push_back(mk(14'h200, 1, 0, 0, 3'd0, 9'h000));
        vecs.push_back(mk(14'h200, 0, 0, 1, 3'd0, 9'h010));
        vecs.push_back(mk(14'h3C0, 0, 1, 0, 3'd1, 9'h002));
        vecs.push_back(mk(14'h240, 1, 0, 0, 3'd1, 9'h002));
        vecs.push_back(mk(14'h240, 0, 0, 1, 3'd1, 9'h012));
        vecs.push_back(mk(14'h140, 0, 1, 1, 3'd5, 9'h00A));
        vecs.push_back(mk(14'h300, 0, 0, 0, 3'd2, 9'h004));

        do_reset();
        #1;
        check("reset_state", 1'b0, 3'd0, 9'h000);

        for (int i = 0; i < vecs.size(); i++)
            apply($sformatf("vec%0d", i), vecs[i]);

        // wr held three cycles on a new tag: one allocation then refreshes.
        @(negedge clk);
        addr = 14'h300; wr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        wr = 1'b0;
        apply("hold_hit",     mk(14'h300, 0, 0, 1, 3'd2, 9'h018));
        apply("hold_oldgone", mk(14'h080, 0, 0, 0, 3'd3, 9'h006));
        apply("hold_way0",    mk(14'h200, 0, 0, 1, 3'd0, 9'h010));
        apply("hold_way1",    mk(14'h240, 0, 0, 1, 3'd1, 9'h012));
        apply("hold_victim",  mk(14'h380, 0, 0, 0, 3'd3, 9'h006));

        // wr and md together behave as wr.
        apply("wrmd_alloc",   mk(14'h380, 1, 1, 0, 3'd3, 9'h006));
        apply("wrmd_hit",     mk(14'h380, 0, 0, 1, 3'd3, 9'h01C));
        apply("wrmd_victim",  mk(14'h3E0, 0, 0, 0, 3'd4, 9'h008));

        // Reset wins over a simultaneous wr.
        @(negedge clk);
        addr = 14'h3E0; wr = 1'b1; reset_n = 1'b1;
        @(posedge clk);
        #1;
        wr = 1'b0; reset_n = 1'b0;
        apply("rst_prio",     mk(14'h3E0, 0, 0, 0, 3'd0, 9'h000));
        apply("rst_md_miss",  mk(14'h300, 0, 1, 0, 3'd0, 9'h000));
        apply("rst_after_md", mk(14'h300, 1, 0, 0, 3'd0, 9'h000));
        apply("rst_realloc",  mk(14'h300, 0, 0, 1, 3'd0, 9'h018));
        apply("rst_next_free", mk(14'h000, 0, 0, 0, 3'd1, 9'h000));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
